// File: rtl/mtm_tile_feeder.sv
// mtm_tile_feeder: two-entry ping-pong tile buffer streaming one tile row per cycle
module mtm_tile_feeder #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_PE     = 8,
   parameter int IDX_W      = $clog2(NUM_PE)
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic                                           tile_val,
   output logic                                           tile_rdy,
   input  logic [0:NUM_PE-1][0:NUM_PE-1][DATA_WIDTH-1:0]  tile_in,
   input  logic                                           stall,
   output logic                                           row_val,
   output logic [0:NUM_PE-1][DATA_WIDTH-1:0]              row_out,
   output logic [IDX_W-1:0]                               row_idx,
   output logic                                           row_last,
   output logic [1:0]                                     buf_cnt,
   output logic                                           busy
);
   typedef enum logic {IDLE, STREAM} state_t;
   state_t state, state_d;
   logic [1:0] full, full_d;
   logic wr_ptr, rd_ptr, rd_ptr_d, accept;
   logic [IDX_W-1:0] row_cnt, row_cnt_d;
   logic [0:NUM_PE-1][0:NUM_PE-1][DATA_WIDTH-1:0] tile_buf [2];

   // accept into the wr_ptr buffer, issue and retire rows from the rd_ptr buffer
   always_comb begin
      full_d    = full;
      tile_rdy  = rst && !full[wr_ptr];
      accept    = tile_val && tile_rdy;
      row_val   = (state == STREAM) && !stall;
      row_last  = row_val && (row_cnt == IDX_W'(NUM_PE - 1));
      row_idx   = row_cnt;
      row_out   = row_val ? tile_buf[rd_ptr][row_cnt] : '0;
      row_cnt_d = row_val ? row_cnt + IDX_W'(1) : row_cnt;
      rd_ptr_d  = rd_ptr ^ row_last;
      if (accept) full_d[wr_ptr] = 1'b1;
      if (row_last) full_d[rd_ptr] = 1'b0;
      state_d   = full_d[rd_ptr_d] ? STREAM : IDLE;
   end

   // control registers; a reset drops both buffered tiles outright
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         full    <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         row_cnt <= '0;
      end else begin
         state   <= state_d;
         full    <= full_d;
         wr_ptr  <= wr_ptr ^ accept;
         rd_ptr  <= rd_ptr_d;
         row_cnt <= row_cnt_d;
      end
   end

   // tile storage carries no reset; validity is tracked by the full flags
   always_ff @(posedge clk) begin
      if (accept) tile_buf[wr_ptr] <= tile_in;
   end

   assign buf_cnt = {1'b0, full[0]} + {1'b0, full[1]};
   assign busy    = |full;
endmodule
